// File: rtl/multicycle_control_unit.sv
// Moore control FSM and ALU decoder for a multicycle MIPS datapath.
// Outputs are decoded from the state register; write strobes are gated low while RST is high.
module multicycle_control_unit #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] Opcode,
  input  logic [OPW-1:0] Funct,
  input  logic           Zero,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic           Branch,
  output logic           PCEn,
  output logic           IorD,
  output logic           MemWrite,
  output logic           RegWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [2:0]     ALUControl,
  output logic [1:0]     PCSrc,
  output logic           Illegal,
  output logic [STW-1:0] State
);

  typedef enum logic [STW-1:0] {
    FETCH    = STW'(0),
    DECODE   = STW'(1),
    MEMADR   = STW'(2),
    MEMRD    = STW'(3),
    MEMWB    = STW'(4),
    MEMWR    = STW'(5),
    EXECUTE  = STW'(6),
    ALUWB    = STW'(7),
    BRANCH   = STW'(8),
    ADDIEXEC = STW'(9),
    ADDIWB   = STW'(10),
    JUMP     = STW'(11)
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

  localparam logic [OPW-1:0] FN_ADD = OPW'(6'b100000);
  localparam logic [OPW-1:0] FN_SUB = OPW'(6'b100010);
  localparam logic [OPW-1:0] FN_AND = OPW'(6'b100100);
  localparam logic [OPW-1:0] FN_OR  = OPW'(6'b100101);
  localparam logic [OPW-1:0] FN_SLT = OPW'(6'b101010);

  logic [STW-1:0] state_reg;
  logic [STW-1:0] state_next;
  logic           op_illegal;
  logic [1:0]     aluop;
  logic           irwrite_s;
  logic           pcwrite_s;
  logic           branch_s;
  logic           memwrite_s;
  logic           regwrite_s;

  always_comb begin
    op_illegal = 1'b0;
    state_next = FETCH;
    case (state_reg)
      FETCH:    state_next = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEXEC;
          OP_J:         state_next = JUMP;
          default: begin
            state_next = FETCH;
            op_illegal = 1'b1;
          end
        endcase
      end
      // Opcode is still valid here since the IR only loads in FETCH.
      MEMADR:   state_next = (Opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    state_next = MEMWB;
      EXECUTE:  state_next = ALUWB;
      ADDIEXEC: state_next = ADDIWB;
      default:  state_next = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    irwrite_s  = 1'b0;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    aluop      = 2'b00;
    PCSrc      = 2'b00;
    case (state_reg)
      FETCH: begin
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
        ALUSrcB   = 2'b01;
      end
      DECODE:   ALUSrcB = 2'b11;
      MEMADR, ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD:    IorD = 1'b1;
      MEMWB: begin
        regwrite_s = 1'b1;
        MemtoReg   = 1'b1;
      end
      MEMWR: begin
        IorD       = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regwrite_s = 1'b1;
        RegDst     = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        aluop    = 2'b01;
        PCSrc    = 2'b01;
        branch_s = 1'b1;
      end
      ADDIWB:   regwrite_s = 1'b1;
      JUMP: begin
        pcwrite_s = 1'b1;
        PCSrc     = 2'b10;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 3'b010;
    case (aluop)
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (Funct)
          FN_ADD:  ALUControl = 3'b010;
          FN_SUB:  ALUControl = 3'b110;
          FN_AND:  ALUControl = 3'b000;
          FN_OR:   ALUControl = 3'b001;
          FN_SLT:  ALUControl = 3'b111;
          default: ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  assign IRWrite  = irwrite_s  & ~RST;
  assign PCWrite  = pcwrite_s  & ~RST;
  assign Branch   = branch_s   & ~RST;
  assign MemWrite = memwrite_s & ~RST;
  assign RegWrite = regwrite_s & ~RST;
  assign PCEn     = (pcwrite_s | (branch_s & Zero)) & ~RST;
  assign Illegal  = op_illegal;
  assign State    = state_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class state by state.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       IRWrite, PCWrite, Branch, PCEn, IorD, MemWrite, RegWrite;
  logic       RegDst, MemtoReg, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit #(.OPW(6), .STW(4)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .PCEn(PCEn),
    .IorD(IorD), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .Illegal(Illegal), .State(State)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; Opcode = 6'b000000; Funct = 6'b100000; Zero = 1'b0;
    tick(); tick();
    check("rst_state", State, 0);
    check("rst_irwrite_gated", IRWrite, 0);
    check("rst_pcen_gated", PCEn, 0);
    RST = 1'b0;
    #1;
    check("fetch_irwrite", IRWrite, 1);

    // lw
    Opcode = 6'b100011;
    tick(); check("lw_s1", State, 1); check("lw_dec_irwrite", IRWrite, 0);
    check("lw_dec_srcb", ALUSrcB, 2'b11); check("lw_dec_illegal", Illegal, 0);
    tick(); check("lw_s2", State, 2); check("lw_adr_srca", ALUSrcA, 1);
    check("lw_adr_srcb", ALUSrcB, 2'b10);
    tick(); check("lw_s3", State, 3); check("lw_rd_iord", IorD, 1);
    check("lw_rd_irwrite", IRWrite, 0);
    tick(); check("lw_s4", State, 4); check("lw_wb_regwrite", RegWrite, 1);
    check("lw_wb_memtoreg", MemtoReg, 1); check("lw_wb_regdst", RegDst, 0);
    tick(); check("lw_s0", State, 0); check("lw_fetch_irwrite", IRWrite, 1);

    // R-type sub then slt
    Opcode = 6'b000000; Funct = 6'b100010;
    tick(); check("sub_s1", State, 1);
    tick(); check("sub_s6", State, 6); check("sub_aluctl", ALUControl, 3'b110);
    check("sub_srca", ALUSrcA, 1); check("sub_srcb", ALUSrcB, 2'b00);
    tick(); check("sub_s7", State, 7); check("sub_regwrite", RegWrite, 1);
    check("sub_regdst", RegDst, 1);
    tick(); check("sub_s0", State, 0);
    Funct = 6'b101010;
    tick(); tick(); check("slt_s6", State, 6); check("slt_aluctl", ALUControl, 3'b111);
    tick(); check("slt_s7", State, 7);
    tick(); check("slt_s0", State, 0);

    // beq taken / not taken
    Opcode = 6'b000100; Zero = 1'b1;
    tick(); tick(); check("beq1_s8", State, 8); check("beq1_pcen", PCEn, 1);
    check("beq1_pcsrc", PCSrc, 2'b01); check("beq1_aluctl", ALUControl, 3'b110);
    tick(); check("beq1_s0", State, 0);
    Zero = 1'b0;
    tick(); tick(); check("beq0_s8", State, 8); check("beq0_pcen", PCEn, 0);
    check("beq0_pcsrc", PCSrc, 2'b01); check("beq0_aluctl", ALUControl, 3'b110);
    tick(); check("beq0_s0", State, 0);

    // j then addi
    Opcode = 6'b000010;
    tick(); tick(); check("j_s11", State, 11); check("j_pcsrc", PCSrc, 2'b10);
    check("j_pcen", PCEn, 1);
    tick(); check("j_s0", State, 0);
    Opcode = 6'b001000;
    tick(); tick(); check("addi_s9", State, 9); check("addi_srcb", ALUSrcB, 2'b10);
    check("addi_aluctl", ALUControl, 3'b010);
    tick(); check("addi_s10", State, 10); check("addi_regwrite", RegWrite, 1);
    check("addi_regdst", RegDst, 0);
    tick(); check("addi_s0", State, 0);

    // illegal opcode
    Opcode = 6'b111111;
    tick(); check("ill_s1", State, 1); check("ill_flag", Illegal, 1);
    check("ill_regwrite", RegWrite, 0); check("ill_memwrite", MemWrite, 0);
    tick(); check("ill_s0", State, 0); check("ill_flag_clr", Illegal, 0);

    // unused encoding
    force dut.state_reg = 4'd13;
    #1;
    check("s13_next", dut.state_next, 0);
    check("s13_irwrite", IRWrite, 0); check("s13_pcen", PCEn, 0);
    check("s13_regwrite", RegWrite, 0); check("s13_memwrite", MemWrite, 0);
    release dut.state_reg;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check("resync_s0", State, 0);

    // reset mid-sw in MEMWR
    Opcode = 6'b101011;
    tick(); tick(); tick(); check("sw_s5", State, 5); check("sw_memwrite", MemWrite, 1);
    check("sw_iord", IorD, 1);
    RST = 1'b1;
    #1;
    check("sw_rst_memwrite", MemWrite, 0);
    tick(); check("sw_rst1_state", State, 0); check("sw_rst1_memwrite", MemWrite, 0);
    tick(); check("sw_rst2_state", State, 0); check("sw_rst2_irwrite", IRWrite, 0);
    RST = 1'b0;
    #1;
    check("post_rst_irwrite", IRWrite, 1); check("post_rst_pcen", PCEn, 1);
    tick(); check("post_rst_s1", State, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
